// File: rtl/mips_pkg.sv
// Purpose: shared definitions for the MIPS HI/LO multiply-divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // One product or quotient bit is produced per iteration.
    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Purpose: request/result bundle between the datapath and the HI/LO unit.
// Latency: n/a (wires only).
// Backpressure: none on the bundle; the requester watches busy/done.
//   master: drives start, op, Aout, Bout, hi_write, lo_write, wdata.
//   slave : drives busy, done, Hi, Lo, err.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] Aout;
    logic [WIDTH-1:0] Bout;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             err;

    modport master (
        output start, op, Aout, Bout, hi_write, lo_write, wdata,
        input  busy, done, Hi, Lo, err
    );

    modport slave (
        input  start, op, Aout, Bout, hi_write, lo_write, wdata,
        output busy, done, Hi, Lo, err
    );
endinterface

// File: rtl/muldiv_step.sv
// Purpose: one shift-add (multiply) or restoring-subtract (divide) iteration.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to load it.
//   acc     : {upper, lower} working register (product, or remainder:quotient)
//   opnd    : multiplicand magnitude, or divisor magnitude
//   is_div  : present only with MULT_DIV_DIVIDE_EN; selects the divide step
//   acc_nxt : register value after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULT_DIV_DIVIDE_EN
    input  logic               is_div,
`endif
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);

`ifdef MULT_DIV_DIVIDE_EN
    // One adder serves both ops. For divide it computes a + ~b + 1, so the
    // top bit is the carry-out, i.e. "trial subtraction did not borrow".
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

    always_comb begin
        add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_b   = {1'b0, opnd};
        add_cin = 1'b0;
        if (is_div) begin
            // Partial remainder shifted left with the next dividend bit.
            add_a   = acc[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        q_bit   = 1'b0;
        rem_nxt = '0;
        if (is_div) begin
            q_bit   = sum[WIDTH+1];
            // Restoring: keep the shifted remainder when the subtract borrowed.
            // Either value is below the divisor, so it fits in WIDTH bits.
            rem_nxt = q_bit ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1];
            acc_nxt = {rem_nxt, acc[WIDTH-2:0], q_bit};
        end else if (acc[0]) begin
            acc_nxt = {sum[WIDTH:0], acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end
`else
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // Multiplier bits are consumed from the bottom; the carry re-enters
        // at the top as the whole register shifts right.
        if (acc[0]) begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end
`endif

endmodule

// File: rtl/mult_div.sv
// Purpose: iterative MIPS multiply/divide unit owning the HI/LO registers.
// Latency: 34 cycles start-to-done for an operation, 2 cycles for a rejected one.
// Backpressure: busy is high outside IDLE; start and MTHI/MTLO are ignored then.
//   Clk, reset (async active-low), bus (mult_div_if.slave):
//   start/op/Aout/Bout request, hi_write/lo_write/wdata MTHI/MTLO,
//   busy/done/err status, Hi/Lo architectural registers.
//   Define MULT_DIV_DIVIDE_EN to build the divider; without it DIV/DIVU end
//   with err=1 and leave Hi/Lo untouched.
module mult_div
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       Clk,
    input logic       reset,
    mult_div_if.slave bus
);

    localparam int CNT_W = $clog2(ITERATIONS);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic               is_div_q,  is_div_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               err_q,     err_d;
`ifdef MULT_DIV_DIVIDE_EN
    logic               neg_rem_q,  neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
`endif

    op_e                op_in;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_in     = op_e'(bus.op);
    assign op_signed = op_is_signed(op_in);
    // |0x80000000| is still 0x80000000 when read as unsigned, which is what
    // the unsigned iterations want.
    assign a_mag = (op_signed && bus.Aout[WIDTH-1]) ? -bus.Aout : bus.Aout;
    assign b_mag = (op_signed && bus.Bout[WIDTH-1]) ? -bus.Bout : bus.Bout;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
`ifdef MULT_DIV_DIVIDE_EN
    // Truncating division: quotient takes sign(A^B), remainder takes sign(A).
    assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
`ifdef MULT_DIV_DIVIDE_EN
        .is_div  (is_div_q),
`endif
        .acc     (acc_q),
        .opnd    (opnd_q),
        .acc_nxt (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        err_d     = err_q;
`ifdef MULT_DIV_DIVIDE_EN
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // A coinciding MTHI/MTLO is dropped: start wins.
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    is_div_d  = bus.op[1];
                    neg_res_d = op_signed & (bus.Aout[WIDTH-1] ^ bus.Bout[WIDTH-1]);
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
`ifdef MULT_DIV_DIVIDE_EN
                        neg_rem_d  = op_signed & bus.Aout[WIDTH-1];
                        div_zero_d = (bus.Bout == '0);
                        state_d    = (bus.Bout == '0) ? FIX : DIV;
`else
                        state_d = FIX;
`endif
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = MUL;
                    end
                end else begin
                    if (bus.hi_write) hi_d = bus.wdata;
                    if (bus.lo_write) lo_d = bus.wdata;
                end
            end

            MUL: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = FIX;
            end

`ifdef MULT_DIV_DIVIDE_EN
            DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = FIX;
            end
`endif

            FIX: begin
                state_d = DONE;
`ifdef MULT_DIV_DIVIDE_EN
                if (div_zero_q) begin
                    err_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`else
                if (is_div_q) begin
                    err_d = 1'b1;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`endif
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            err_q      <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            err_q      <= err_d;
`ifdef MULT_DIV_DIVIDE_EN
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_mult_div.sv
// Purpose: self-checking bench for mult_div against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_div;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div #(.WIDTH(32)) u_dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MULT_DIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_err;
    int          exp_lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa      = longint'($signed(a));
        sb      = longint'($signed(b));
        exp_err = 1'b0;
        exp_lat = 34;
        exp_hi  = mdl_hi;
        exp_lo  = mdl_lo;
        case (op)
            2'b00: begin
                p      = sa * sb;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            2'b01: begin
                p      = {32'd0, a} * {32'd0, b};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            default: begin
                if (!DIV_EN || b == 32'd0) begin
                    exp_err = 1'b1;
                    exp_lat = 2;
                end else if (op == 2'b10) begin
                    q      = sa / sb;
                    r      = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
        endcase
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic mt(input bit to_hi, input logic [31:0] d);
        bus.hi_write = to_hi;
        bus.lo_write = !to_hi;
        bus.wdata    = d;
        @(posedge clk);
        @(negedge clk);
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        if (to_hi) begin
            mdl_hi = d;
            chk("mthi", bus.Hi, d);
        end else begin
            mdl_lo = d;
            chk("mtlo", bus.Lo, d);
        end
    endtask

    // with_wr: raise MTHI/MTLO together with start.
    // intrude: cycle at which a competing start (plus an MTLO) is driven; 0 = none.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit with_wr, input int intrude);
        int cyc;
        int extra;
        model(op, a, b);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.Aout     = a;
        bus.Bout     = b;
        bus.hi_write = with_wr;
        bus.lo_write = with_wr;
        bus.wdata    = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        cyc = 1;
        chk({nm, " busy"}, bus.busy, 1);
        while (bus.done !== 1'b1 && cyc < 80) begin
            if (intrude != 0 && cyc == intrude) begin
                bus.start    = 1'b1;
                bus.op       = 2'b01;
                bus.Aout     = $urandom;
                bus.Bout     = $urandom | 32'h1;
                bus.lo_write = 1'b1;
                bus.wdata    = 32'h5555_AAAA;
            end else begin
                bus.start    = 1'b0;
                bus.lo_write = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.lo_write = 1'b0;
        chk({nm, " done_cycle"}, cyc, exp_lat);
        chk({nm, " Hi"}, bus.Hi, exp_hi);
        chk({nm, " Lo"}, bus.Lo, exp_lo);
        chk({nm, " err"}, bus.err, exp_err);
        mdl_hi = exp_hi;
        mdl_lo = exp_lo;
        @(negedge clk);
        chk({nm, " done_pulse"}, bus.done, 0);
        chk({nm, " idle"}, bus.busy, 0);
        chk({nm, " err_hold"}, bus.err, exp_err);
        if (intrude != 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.done === 1'b1) extra++;
            end
            chk({nm, " extra_done"}, extra, 0);
            chk({nm, " Lo_kept"}, bus.Lo, exp_lo);
        end
    endtask

    initial begin
        int extra;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.Aout     = '0;
        bus.Bout     = '0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.wdata    = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst Hi", bus.Hi, 0);
        chk("rst Lo", bus.Lo, 0);
        chk("rst err", bus.err, 0);

        // Start lands on the first rising edge after reset release.
        reset = 1'b1;
        run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0, 0);
        run_op("mult_m1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op("divu_7d2", 2'b11, 32'd7, 32'd2, 1'b0, 0);
        mt(1'b1, 32'h0000_1234);
        mt(1'b0, 32'h0000_5678);
        run_op("divu_by0", 2'b11, 32'h0000_0099, 32'd0, 1'b0, 1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("start_vs_wr", 2'b01, 32'h10, 32'h20, 1'b1, 0);
        run_op("mult_intrude", 2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b0, 5);

        // Reset in the middle of a MULTU.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.Aout  = 32'h7777_7777;
        bus.Bout  = 32'h0000_0123;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 0);
        chk("midrst Hi", bus.Hi, 0);
        chk("midrst Lo", bus.Lo, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst err", bus.err, 0);
        mdl_hi = '0;
        mdl_lo = '0;
        extra  = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("midrst no_done", extra, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            if ($urandom_range(3) == 0) mt(1'($urandom_range(1)), $urandom);
            rop = 2'($urandom_range(3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("rand", rop, ra, rb, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port Clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low; asserting it clears all state immediately.
REQ-004 SHALL have port start, input, 1, one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports Aout and Bout, input, 32 each, operands; Aout is the multiplicand or dividend, Bout the multiplier or divisor.
REQ-007 SHALL have ports hi_write and lo_write, input, 1 each, MTHI/MTLO strobes.
REQ-008 SHALL have port wdata, input, 32, data for MTHI/MTLO.
REQ-009 SHALL have ports busy and done, output, 1 each; busy is high in any non-IDLE state; done is a one-cycle completion pulse.
REQ-010 SHALL have ports Hi and Lo, output, 32 each, architectural HI/LO registers, read by the datapath for MFHI/MFLO.
REQ-011 SHALL have port err, output, 1; it is valid with done and flags divide-by-zero or an unsupported op.

Function
REQ-012 SHALL implement the FSM with states IDLE, MUL, DIV, FIX, DONE.
- IDLE to MUL or DIV on start.
- MUL or DIV to FIX after 32 iterations.
- FIX to DONE.
- DONE to IDLE.
REQ-013 SHALL, when start is sampled in IDLE, latch the operands, take magnitudes for signed ops, and record the result and remainder signs.
REQ-014 SHALL perform MUL as radix-2 shift-add, one bit per cycle, over a 64-bit product register.
REQ-015 SHALL perform DIV as restoring division, one quotient bit per cycle.
REQ-016 SHALL, in FIX, apply sign correction and write Hi and Lo:
- MULT/MULTU: Hi gets product[63:32] and Lo gets product[31:0].
- DIV/DIVU: Lo gets the quotient and Hi gets the remainder.
REQ-017 SHALL give the signed quotient the sign of Aout XOR Bout and the remainder the sign of Aout (truncating division).
REQ-018 SHALL assert done in DONE exactly 34 cycles after the edge that sampled start; Hi and Lo hold their new values from that cycle onward.
REQ-019 SHALL ignore start while busy; the operation in flight is unaffected.
REQ-020 SHALL, for DIV/DIVU with Bout=0, skip the iterations (IDLE to FIX to DONE), leave Hi and Lo unchanged, and set err with done, 2 cycles after start.
REQ-021 SHALL give DIV of 0x80000000 by 0xFFFFFFFF the result Lo=0x80000000, Hi=0, err=0.
REQ-022 SHALL apply hi_write or lo_write only in IDLE with start low; writes take effect next edge and are ignored otherwise.
REQ-023 SHALL give start priority when it coincides with a write; the write is dropped.
REQ-024 SHALL hold err until the next start is accepted.

Reset
REQ-025 SHALL, on reset low at any time including mid-operation, force the state to IDLE, clear the iteration counter, and set Hi=0, Lo=0, busy=0, done=0, err=0.
REQ-026 SHALL accept start on the first rising edge after reset is released.

Configuration
REQ-027 SHALL compile in the DIV state and divider datapath when macro MULT_DIV_DIVIDE_EN is defined.
REQ-028 SHALL, without MULT_DIV_DIVIDE_EN, handle ops 10 and 11 as follows: IDLE to FIX to DONE, Hi and Lo unchanged, err=1, done 2 cycles after start; MULT/MULTU are unaffected.

Structure
REQ-029 SHALL place the op encoding enum, the FSM state enum and the ITERATIONS=32 constant in the shared package mips_pkg.
REQ-030 SHALL contain the single-iteration add/subtract-and-shift logic in sub-module muldiv_step, instantiated once and shared by MUL and DIV.

Verification
REQ-031 SHALL cover MULTU with Aout=3, Bout=4: expect done at cycle 34, Hi=0x00000000, Lo=0x0000000C, err=0.
REQ-032 SHALL cover MULT with Aout=0xFFFFFFFF, Bout=2: expect Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
REQ-033 SHALL cover DIV with Aout=0xFFFFFFF9 (-7), Bout=2: expect Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU with 7 and 2: expect Lo=3, Hi=1.
REQ-034 SHALL cover DIVU with Bout=0 after MTHI 0x1234 and MTLO 0x5678: expect done at cycle 2 with err=1 and Hi/Lo unchanged.
REQ-035 SHALL cover MULTU started, then reset low at cycle 10: expect busy=0 and Hi=Lo=0 immediately, and no done pulse.
REQ-036 SHALL cover a second start with different operands at cycle 5 of a MULT: expect it ignored, the first result delivered at cycle 34, and exactly one done pulse.
